// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiplier and restoring divider share one 128-bit
// {hi, lo} working register. Operands are reduced to magnitudes at start
// and the result is negated on the way out when the signs require it.
// Divide-by-zero and signed overflow bypass the iterative loop entirely.

module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [63:0] hi_r;
    logic [63:0] lo_r;
    logic [63:0] opnd_r;
    logic [2:0]  f3_r;
    logic        w_r;
    logic        neg_r;
    logic        special_r;
    logic [63:0] spec_res_r;
    logic [4:0]  rd_r;

    logic        is_w_s;
    logic        mop_s;
    logic        is_div_s;
    logic        sgn1_s;
    logic        sgn2_s;
    logic [63:0] op1_ext_s;
    logic [63:0] op2_ext_s;
    logic        s1_s;
    logic        s2_s;
    logic [63:0] mag1_s;
    logic [63:0] mag2_s;
    logic        div0_s;
    logic        ovf_s;
    logic        neg_s;
    logic [63:0] min_neg_s;
    logic [63:0] w_rs1_s;
    logic [63:0] spec_s;
    logic [63:0] load_hi_s;
    logic [63:0] load_lo_s;
    logic [63:0] load_opnd_s;

    logic [64:0] sum_s;
    logic [64:0] trial_s;
    logic [63:0] next_hi_s;
    logic [63:0] next_lo_s;
    logic        last_s;

    logic [63:0] mulh_s;
    logic [63:0] qv_s;
    logic [63:0] rv_s;
    logic [63:0] final_s;
    logic        valid_s;

    // Decode the ID/EX instruction and prepare magnitudes, signs and special cases.
    always_comb begin
        is_w_s   = (opcode_i == OPC_OP32);
        mop_s    = (funct7_i == F7_MULDIV) &&
                   ((opcode_i == OPC_OP) ||
                    (is_w_s && ((funct3_i == 3'd0) || funct3_i[2])));
        is_div_s = funct3_i[2];
        if (is_div_s) begin
            sgn1_s = ~funct3_i[0];
            sgn2_s = ~funct3_i[0];
        end else begin
            sgn1_s = (funct3_i == 3'd1) || (funct3_i == 3'd2);
            sgn2_s = (funct3_i == 3'd1);
        end
        if (is_w_s) begin
            op1_ext_s = sgn1_s ? sext32(rs1_data_i[31:0]) : {32'd0, rs1_data_i[31:0]};
            op2_ext_s = sgn2_s ? sext32(rs2_data_i[31:0]) : {32'd0, rs2_data_i[31:0]};
            min_neg_s = 64'hFFFF_FFFF_8000_0000;
            w_rs1_s   = sext32(rs1_data_i[31:0]);
        end else begin
            op1_ext_s = rs1_data_i;
            op2_ext_s = rs2_data_i;
            min_neg_s = 64'h8000_0000_0000_0000;
            w_rs1_s   = rs1_data_i;
        end
        s1_s   = sgn1_s & op1_ext_s[63];
        s2_s   = sgn2_s & op2_ext_s[63];
        mag1_s = s1_s ? (64'd0 - op1_ext_s) : op1_ext_s;
        mag2_s = s2_s ? (64'd0 - op2_ext_s) : op2_ext_s;
        div0_s = is_div_s && (op2_ext_s == 64'd0);
        ovf_s  = is_div_s && sgn1_s && (op1_ext_s == min_neg_s) &&
                 (op2_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
        if (is_div_s && funct3_i[1]) begin
            neg_s = s1_s;
        end else begin
            neg_s = s1_s ^ s2_s;
        end
        if (div0_s) begin
            spec_s = funct3_i[1] ? w_rs1_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_s = funct3_i[1] ? 64'd0 : w_rs1_s;
        end
        load_hi_s = 64'd0;
        if (is_div_s) begin
            load_lo_s   = is_w_s ? {mag1_s[31:0], 32'd0} : mag1_s;
            load_opnd_s = mag2_s;
        end else begin
            load_lo_s   = mag2_s;
            load_opnd_s = mag1_s;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : 65'd0);
        trial_s = {hi_r, lo_r[63]} - {1'b0, opnd_r};
        if (f3_r[2]) begin
            if (!trial_s[64]) begin
                next_hi_s = trial_s[63:0];
                next_lo_s = {lo_r[62:0], 1'b1};
            end else begin
                next_hi_s = {hi_r[62:0], lo_r[63]};
                next_lo_s = {lo_r[62:0], 1'b0};
            end
        end else begin
            next_hi_s = sum_s[64:1];
            next_lo_s = {sum_s[0], lo_r[63:1]};
        end
        last_s = w_r ? (cnt_r == 6'd31) : (cnt_r == 6'd63);
    end

    // Select and sign-correct the final result from the working registers.
    always_comb begin
        mulh_s = neg_r ? (~hi_r + ((lo_r == 64'd0) ? 64'd1 : 64'd0)) : hi_r;
        qv_s   = neg_r ? (64'd0 - lo_r) : lo_r;
        rv_s   = neg_r ? (64'd0 - hi_r) : hi_r;
        if (special_r) begin
            final_s = spec_res_r;
        end else begin
            case (f3_r)
                3'd0:          final_s = w_r ? sext32(lo_r[63:32]) : lo_r;
                3'd1, 3'd2,
                3'd3:          final_s = mulh_s;
                3'd4, 3'd5:    final_s = w_r ? sext32(qv_s[31:0]) : qv_s;
                3'd6, 3'd7:    final_s = w_r ? sext32(rv_s[31:0]) : rv_s;
                default:       final_s = 64'd0;
            endcase
        end
    end

    // Pipeline-facing outputs; reset and flush force them inactive.
    always_comb begin
        valid_s        = rst && (state_r == S_DONE) && !flush_i;
        result_valid_o = valid_s;
        result_o       = valid_s ? final_s : 64'd0;
        rd_addr_o      = valid_s ? rd_r : 5'd0;
        busy_o         = rst && (state_r != S_IDLE);
        if (!rst || flush_i) begin
            stall_req_o = 1'b0;
        end else if (state_r == S_IDLE) begin
            stall_req_o = mop_s;
        end else if (state_r == S_BUSY) begin
            stall_req_o = 1'b1;
        end else begin
            stall_req_o = 1'b0;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 6'd0;
            hi_r       <= 64'd0;
            lo_r       <= 64'd0;
            opnd_r     <= 64'd0;
            f3_r       <= 3'd0;
            w_r        <= 1'b0;
            neg_r      <= 1'b0;
            special_r  <= 1'b0;
            spec_res_r <= 64'd0;
            rd_r       <= 5'd0;
        end else if (flush_i) begin
            state_r <= S_IDLE;
            cnt_r   <= 6'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mop_s) begin
                        hi_r       <= load_hi_s;
                        lo_r       <= load_lo_s;
                        opnd_r     <= load_opnd_s;
                        f3_r       <= funct3_i;
                        w_r        <= is_w_s;
                        neg_r      <= neg_s;
                        special_r  <= div0_s | ovf_s;
                        spec_res_r <= spec_s;
                        rd_r       <= rd_addr_i;
                        cnt_r      <= 6'd0;
                        state_r    <= (div0_s | ovf_s) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi_r  <= next_hi_s;
                    lo_r  <= next_lo_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (last_s) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for the iterative multiply/divide unit.

module tb_ex_muldiv;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_W = 7'b0111011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_M = 7'b0000001;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    int          st_n;
    int          vl_n;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic        st_at_v;

    ex_muldiv #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode_i       (opcode),
        .funct3_i       (funct3),
        .funct7_i       (funct7),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .rd_addr_i      (rd_in),
        .flush_i        (flush),
        .stall_req_o    (stall),
        .busy_o         (busy),
        .result_valid_o (valid),
        .result_o       (result),
        .rd_addr_o      (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic bubble();
        opcode = OP_I; funct3 = 3'd0; funct7 = 7'd0;
        rs1 = 64'd0; rs2 = 64'd0; rd_in = 5'd0;
    endtask

    // Present one instruction (called #1 after a rising edge) and hold it until
    // result_valid or max_cyc cycles. Leaves the bench #1 after the DONE edge.
    task automatic exec_op(input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd,
                           input int max_cyc, output int stall_n,
                           output logic [63:0] r, output logic [4:0] ro,
                           output int valid_n, output logic stall_v);
        opcode = opc; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd_in = rd;
        stall_n = 0; valid_n = 0; r = 64'd0; ro = 5'd0; stall_v = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (stall === 1'b1) stall_n++;
            if (valid === 1'b1) begin
                valid_n++; r = result; ro = rd_out; stall_v = stall;
            end
            @(posedge clk);
            #1;
            if (valid_n > 0) break;
        end
        bubble();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        opcode = OP_R; funct3 = 3'd0; funct7 = F7_M;
        rs1 = 64'd7; rs2 = 64'd9; rd_in = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, busy, valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {stall, busy, valid});
        end
        checks++;
        if ({result, rd_out} !== 69'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", result, rd_out);
        end
        @(posedge clk); #1;
        bubble(); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        exec_op(OP_R, 3'd0, F7_M, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd13, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (st_n !== 65) begin errors++; $display("FAIL mul_stall: got %0d expected 65", st_n); end
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL mul_result: got %h expected ffffffffffffffeb", res);
        end
        checks++;
        if (rdo !== 5'd13) begin errors++; $display("FAIL mul_rd: got %0d expected 13", rdo); end
        checks++;
        if ({vl_n == 1, st_at_v} !== 2'b10) begin
            errors++; $display("FAIL mul_valid: got valid_n=%0d stall=%b expected 1/0", vl_n, st_at_v);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL mul_valid_once: got %b expected 0", valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mulh();
        exec_op(OP_R, 3'd3, F7_M, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE || st_n !== 65) begin
            errors++; $display("FAIL mulhu: got %h stall %0d expected fffffffffffffffe stall 65", res, st_n);
        end
        exec_op(OP_R, 3'd2, F7_M, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL mulhsu: got %h expected ffffffffffffffff", res);
        end
        exec_op(OP_R, 3'd1, F7_M, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd3, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL mulh: got %h expected ffffffffffffffff", res);
        end
        exec_op(OP_W, 3'd0, F7_M, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd4, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE || st_n !== 33) begin
            errors++; $display("FAIL mulw: got %h stall %0d expected fffffffffffffffe stall 33", res, st_n);
        end
    endtask

    task automatic test_divw();
        exec_op(OP_W, 3'd4, F7_M, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd5, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD || st_n !== 33) begin
            errors++; $display("FAIL divw: got %h stall %0d expected fffffffffffffffd stall 33", res, st_n);
        end
        exec_op(OP_W, 3'd6, F7_M, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 200,
                st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF || st_n !== 33) begin
            errors++; $display("FAIL remw: got %h stall %0d expected ffffffffffffffff stall 33", res, st_n);
        end
    endtask

    task automatic test_special();
        logic [6:0]  opc_t [5];
        logic [2:0]  f3_t  [5];
        logic [63:0] a_t   [5];
        logic [63:0] b_t   [5];
        logic [63:0] exp_t [5];
        opc_t[0] = OP_R; f3_t[0] = 3'd5; a_t[0] = 64'h1234;                b_t[0] = 64'd0;
        exp_t[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        opc_t[1] = OP_R; f3_t[1] = 3'd6; a_t[1] = 64'd5;                   b_t[1] = 64'd0;
        exp_t[1] = 64'd5;
        opc_t[2] = OP_R; f3_t[2] = 3'd4; a_t[2] = 64'h8000_0000_0000_0000; b_t[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_t[2] = 64'h8000_0000_0000_0000;
        opc_t[3] = OP_R; f3_t[3] = 3'd6; a_t[3] = 64'h8000_0000_0000_0000; b_t[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_t[3] = 64'd0;
        opc_t[4] = OP_W; f3_t[4] = 3'd7; a_t[4] = 64'h0000_0000_8000_0005; b_t[4] = 64'hFFFF_FFFF_0000_0000;
        exp_t[4] = 64'hFFFF_FFFF_8000_0005;
        for (int k = 0; k < 5; k++) begin
            exec_op(opc_t[k], f3_t[k], F7_M, a_t[k], b_t[k], 5'd20 + 5'(k), 10,
                    st_n, res, rdo, vl_n, st_at_v);
            checks++;
            if (res !== exp_t[k] || st_n !== 1 || vl_n !== 1 || rdo !== 5'd20 + 5'(k)) begin
                errors++;
                $display("FAIL special%0d: got %h stall %0d valid %0d rd %0d expected %h stall 1 valid 1 rd %0d",
                         k, res, st_n, vl_n, rdo, exp_t[k], 20 + k);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1;
        int          s1;
        logic        sv1;
        exec_op(OP_R, 3'd4, F7_M, 64'd100, 64'd7, 5'd8, 200, s1, r1, rdo, vl_n, sv1);
        exec_op(OP_R, 3'd6, F7_M, 64'd100, 64'd7, 5'd9, 200, st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (r1 !== 64'd14 || res !== 64'd2) begin
            errors++; $display("FAIL b2b_result: got %0d,%0d expected 14,2", r1, res);
        end
        checks++;
        if (s1 !== 65 || st_n !== 65 || sv1 !== 1'b0) begin
            errors++; $display("FAIL b2b_stall: got %0d,%0d done_stall=%b expected 65,65,0", s1, st_n, sv1);
        end
    endtask

    task automatic test_non_mop();
        exec_op(OP_R, 3'd0, 7'd0, 64'd1, 64'd2, 5'd1, 5, st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (st_n !== 0 || vl_n !== 0) begin
            errors++; $display("FAIL add_ignored: got stall %0d valid %0d expected 0 0", st_n, vl_n);
        end
        exec_op(OP_I, 3'd0, 7'd0, 64'd0, 64'd0, 5'd0, 5, st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (st_n !== 0 || vl_n !== 0) begin
            errors++; $display("FAIL bubble_ignored: got stall %0d valid %0d expected 0 0", st_n, vl_n);
        end
        exec_op(OP_W, 3'd1, F7_M, 64'd3, 64'd4, 5'd2, 5, st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (st_n !== 0 || vl_n !== 0) begin
            errors++; $display("FAIL w_mulh_ignored: got stall %0d valid %0d expected 0 0", st_n, vl_n);
        end
    endtask

    task automatic test_flush();
        int vseen;
        opcode = OP_R; funct3 = 3'd4; funct7 = F7_M; rs1 = 64'd100; rs2 = 64'd7; rd_in = 5'd9;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1; bubble();
        @(negedge clk);
        checks++;
        if ({stall, valid, busy} !== 3'b001) begin
            errors++; $display("FAIL flush_cycle: got stall/valid/busy %b expected 001", {stall, valid, busy});
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, busy} !== 2'b00) begin
            errors++; $display("FAIL flush_idle: got stall/busy %b expected 00", {stall, busy});
        end
        vseen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vseen++;
        end
        checks++;
        if (vseen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d expected 0", vseen); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        opcode = OP_R; funct3 = 3'd0; funct7 = F7_M; rs1 = 64'd5; rs2 = 64'd6; rd_in = 5'd7;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, busy, valid} !== 3'b000 || result !== 64'd0 || rd_out !== 5'd0) begin
            errors++; $display("FAIL rst_mid_out: got ctrl %b result %h rd %0d expected 000/0/0",
                               {stall, busy, valid}, result, rd_out);
        end
        @(posedge clk); #1;
        rst = 1'b1; bubble();
        @(negedge clk);
        checks++;
        if ({stall, busy} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_idle: got stall/busy %b expected 00", {stall, busy});
        end
        @(posedge clk); #1;
        exec_op(OP_R, 3'd0, F7_M, 64'd3, 64'd4, 5'd11, 200, st_n, res, rdo, vl_n, st_at_v);
        checks++;
        if (res !== 64'd12 || st_n !== 65 || rdo !== 5'd11) begin
            errors++; $display("FAIL rst_mid_mul: got %0d stall %0d rd %0d expected 12 stall 65 rd 11",
                               res, st_n, rdo);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_divw();
        test_special();
        test_back_to_back();
        test_non_mop();
        test_flush();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
